// File: rtl/seg_scan_decoder_if.sv
// Scanned seven-segment bus plus the decoded frame published by seg_scan_decoder.
// master drives the scan lines; slave (the decoder) returns the published frame.
interface seg_scan_decoder_if;
  logic [6:0]  segment;
  logic [3:0]  digit_en;
  logic [15:0] digits;
  logic [3:0]  blank_mask;
  logic [3:0]  bad_mask;
  logic        frame_valid;
  logic        link_ok;

  modport master (
    output segment, digit_en,
    input  digits, blank_mask, bad_mask, frame_valid, link_ok
  );

  modport slave (
    input  segment, digit_en,
    output digits, blank_mask, bad_mask, frame_valid, link_ok
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Rebuilds BCD digits from a scanned 4-digit seven-segment bus; publishes after STABLE_FRAMES repeats.
// Latency SETTLE_CYCLES+2 from last digit enable to frame_valid; no backpressure, pure monitor.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int STABLE_FRAMES  = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clock,
  input  logic               reset,
  seg_scan_decoder_if.slave  bus
);

  typedef enum logic [1:0] {WAIT, SETTLE, DONE} state_t;

  localparam logic [7:0]  SETTLE_LIM = 8'(SETTLE_CYCLES);
  localparam logic [3:0]  STABLE_LIM = 4'(STABLE_FRAMES);
  localparam logic [15:0] TO_MAX     = 16'(TIMEOUT_CYCLES);

  state_t      state, state_nxt;
  logic [6:0]  seg_r, seg_p;
  logic [3:0]  en_r, en_p;
  logic [7:0]  settle_cnt, settle_nxt;
  logic        sample;
  logic        en_onehot;

  logic [3:0]  cap_mask;
  logic [15:0] work_code;
  logic [3:0]  work_blank, work_bad;
  logic [23:0] prev_frame;
  logic        prev_vld;
  logic [3:0]  match_cnt, match_nxt;
  logic [15:0] to_cnt;

  logic        frame_done, same, publish, timeout_hit;
  logic [3:0]  code;

  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'h3F:   decode = 4'h0;
      7'h06:   decode = 4'h1;
      7'h5B:   decode = 4'h2;
      7'h4F:   decode = 4'h3;
      7'h66:   decode = 4'h4;
      7'h6D:   decode = 4'h5;
      7'h7D:   decode = 4'h6;
      7'h07:   decode = 4'h7;
      7'h7F:   decode = 4'h8;
      7'h6F:   decode = 4'h9;
      7'h00:   decode = 4'hF;
      default: decode = 4'hE;
    endcase
  endfunction

  assign en_onehot = (en_r != 4'b0) && ((en_r & (en_r - 4'd1)) == 4'b0);
  assign code      = decode(seg_r);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= WAIT;
      settle_cnt <= 8'd0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    sample     = 1'b0;
    case (state)
      WAIT: begin
        if (en_onehot) begin
          settle_nxt = 8'd1;
          state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        if ((en_r != en_p) || (seg_r != seg_p) || !en_onehot) begin
          state_nxt = WAIT;
        end else begin
          settle_nxt = settle_cnt + 8'd1;
          if (settle_nxt >= SETTLE_LIM) begin
            sample    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (en_r != en_p) state_nxt = WAIT;
      end
      default: state_nxt = WAIT;
    endcase
  end

  // Frame bookkeeping: completion is evaluated on the cycle after the mask fills.
  assign frame_done  = (cap_mask == 4'hF);
  assign same        = prev_vld && ({work_code, work_blank, work_bad} == prev_frame);
  assign match_nxt   = !frame_done ? match_cnt :
                       !same       ? 4'd1 :
                       (match_cnt == 4'd15) ? 4'd15 : match_cnt + 4'd1;
  // A saturated repeat must not count as "becoming" STABLE_FRAMES again.
  assign publish     = frame_done && (match_nxt == STABLE_LIM) && (!same || match_cnt != 4'd15);
  assign timeout_hit = !frame_done && (to_cnt == TO_MAX - 16'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_r       <= 7'd0;
      seg_p       <= 7'd0;
      en_r        <= 4'd0;
      en_p        <= 4'd0;
      cap_mask    <= 4'd0;
      work_code   <= 16'd0;
      work_blank  <= 4'd0;
      work_bad    <= 4'd0;
      prev_frame  <= 24'd0;
      prev_vld    <= 1'b0;
      match_cnt   <= 4'd0;
      to_cnt      <= 16'd0;
      bus.digits      <= 16'h0000;
      bus.blank_mask  <= 4'hF;
      bus.bad_mask    <= 4'h0;
      bus.frame_valid <= 1'b0;
      bus.link_ok     <= 1'b0;
    end else begin
      seg_r <= bus.segment;
      en_r  <= bus.digit_en;
      seg_p <= seg_r;
      en_p  <= en_r;

      cap_mask <= (frame_done ? 4'd0 : cap_mask) | (sample ? en_r : 4'd0);
      for (int n = 0; n < 4; n++) begin
        if (sample && en_r[n]) begin
          work_code[n*4 +: 4] <= code;
          work_blank[n]       <= (seg_r == 7'h00);
          work_bad[n]         <= (code == 4'hE);
        end
      end

      if (frame_done) begin
        prev_frame <= {work_code, work_blank, work_bad};
        prev_vld   <= 1'b1;
        to_cnt     <= 16'd0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 16'd1;
      end

      match_cnt <= timeout_hit ? 4'd0 : match_nxt;

      bus.frame_valid <= publish;
      if (publish) begin
        bus.digits     <= work_code;
        bus.blank_mask <= work_blank;
        bus.bad_mask   <= work_bad;
      end

      if (timeout_hit)  bus.link_ok <= 1'b0;
      else if (publish) bus.link_ok <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scans of seg_scan_decoder; expected publishes queued by stimulus, checked by a monitor.
module tb_seg_scan_decoder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  seg_scan_decoder_if bus();

  seg_scan_decoder #(
    .SETTLE_CYCLES (8),
    .STABLE_FRAMES (3),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  blank;
    logic [3:0]  bad;
    logic        link;
    logic [7:0]  tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_vec   = 0;
  int         n_bad   = 0;
  int         cyc     = 0;
  int         last_fv = 0;
  logic [7:0] cur_tag = 8'h00;

  localparam logic [6:0] S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
  localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, SBLANK = 7'h00, SBAD = 7'h49;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (tag %0h)", name, act, req, cur_tag);
    end
  endtask

  always @(posedge clock) cyc++;

  // Monitor: every frame_valid must match the oldest queued expectation.
  always @(posedge clock) begin
    #1;
    if (bus.frame_valid === 1'b1) begin
      last_fv = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_publish: digits %0h at tag %0h, none expected", bus.digits, cur_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("pub_digits", 32'(bus.digits), 32'(mon_e.digits));
        check("pub_blank",  32'(bus.blank_mask), 32'(mon_e.blank));
        check("pub_bad",    32'(bus.bad_mask), 32'(mon_e.bad));
        check("pub_link",   32'(bus.link_ok), 32'(mon_e.link));
        check("pub_frame",  32'(cur_tag), 32'(mon_e.tag));
      end
    end
  end

  task automatic dwell(input int idx, input logic [6:0] s, input bit glitch, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      bus.digit_en = 4'(1 << idx);
      bus.segment  = (glitch && ((c / 4) % 2 == 1)) ? 7'h00 : s;
    end
  endtask

  task automatic scan(input logic [7:0] tag, input logic [6:0] s3, s2, s1, s0, input bit g2);
    cur_tag = tag;
    dwell(3, s3, 1'b0, 16);
    dwell(2, s2, g2,   16);
    dwell(1, s1, 1'b0, 16);
    dwell(0, s0, 1'b0, 16);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      bus.digit_en = 4'h0;
      bus.segment  = 7'h00;
    end
  endtask

  task automatic expect_pub(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bd,
                            input logic [7:0] tag);
    exp_q.push_back('{digits: d, blank: bl, bad: bd, link: 1'b1, tag: tag});
  endtask

  task automatic do_reset();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_digits", 32'(bus.digits), 32'h0000);
    check("rst_blank",  32'(bus.blank_mask), 32'hF);
    check("rst_bad",    32'(bus.bad_mask), 32'h0);
    check("rst_fv",     32'(bus.frame_valid), 32'h0);
    check("rst_link",   32'(bus.link_ok), 32'h0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    bus.segment  = 7'h00;
    bus.digit_en = 4'h0;
    repeat (2) @(negedge clock);
    do_reset();
    idle(4);

    // Clean scan 12:34
    expect_pub(16'h1234, 4'h0, 4'h0, 8'h13);
    for (int f = 1; f <= 3; f++) scan(8'(8'h10 + f), S1, S2, S3, S4, 1'b0);
    idle(20);
    do_reset();

    // Glitch on digit2: no frame ever completes
    for (int f = 1; f <= 3; f++) scan(8'(8'h20 + f), S1, S2, S3, S4, 1'b1);
    idle(20);
    check("glitch_link_low", 32'(bus.link_ok), 32'h0);
    do_reset();

    // Blank digit3, undecodable digit0
    expect_pub(16'hF23E, 4'b1000, 4'b0001, 8'h33);
    for (int f = 1; f <= 3; f++) scan(8'(8'h30 + f), SBLANK, S2, S3, SBAD, 1'b0);
    idle(20);
    do_reset();

    // Value change: 12:34 x3, 12:35 x2, 12:36 x3
    expect_pub(16'h1234, 4'h0, 4'h0, 8'h43);
    expect_pub(16'h1236, 4'h0, 4'h0, 8'h48);
    for (int f = 1; f <= 3; f++) scan(8'(8'h40 + f), S1, S2, S3, S4, 1'b0);
    for (int f = 4; f <= 5; f++) scan(8'(8'h40 + f), S1, S2, S3, S5, 1'b0);
    for (int f = 6; f <= 8; f++) scan(8'(8'h40 + f), S1, S2, S3, S6, 1'b0);
    idle(20);
    do_reset();

    // Timeout after publish, then resume
    expect_pub(16'h1234, 4'h0, 4'h0, 8'h53);
    for (int f = 1; f <= 3; f++) scan(8'(8'h50 + f), S1, S2, S3, S4, 1'b0);
    idle(1);
    for (int w = 0; w < 1500; w++) begin
      @(posedge clock);
      #1;
      if (bus.link_ok !== 1'b1) break;
    end
    check("timeout_link_fall",  32'(bus.link_ok), 32'h0);
    check("timeout_delay",      32'(cyc - last_fv), 32'd1000);
    check("timeout_hold_digits", 32'(bus.digits), 32'h1234);
    check("timeout_hold_blank",  32'(bus.blank_mask), 32'h0);
    expect_pub(16'h1234, 4'h0, 4'h0, 8'h56);
    for (int f = 4; f <= 6; f++) scan(8'(8'h50 + f), S1, S2, S3, S4, 1'b0);
    idle(20);
    check("resume_link", 32'(bus.link_ok), 32'h1);
    do_reset();

    // Reset in the middle of a frame after a publish
    expect_pub(16'h1234, 4'h0, 4'h0, 8'h63);
    for (int f = 1; f <= 3; f++) scan(8'(8'h60 + f), S1, S2, S3, S4, 1'b0);
    cur_tag = 8'h64;
    dwell(3, S1, 1'b0, 16);
    dwell(2, S2, 1'b0, 16);
    dwell(1, S3, 1'b0, 5);
    do_reset();
    idle(4);
    expect_pub(16'h1234, 4'h0, 4'h0, 8'h67);
    for (int f = 5; f <= 7; f++) scan(8'(8'h60 + f), S1, S2, S3, S4, 1'b0);
    idle(20);
    check("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
